// File: rtl/tff_pkg.sv
// Shared constants and helpers for the T flip-flop up/down counter.
// Direction encoding plus a ceil-log2 helper for elaboration-time checks.
package tff_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Number of bits needed to hold values 0..v-1.
  function automatic int tff_clog2(input int v);
    int r;
    int p;
    r = 0;
    p = 1;
    while (p < v) begin
      p = p * 2;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/tff_cell.sv
// Single-bit T flip-flop with asynchronous active-high reset.
// qb is the complementary output of the same storage element.
module tff_cell #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q,
  output logic qb
);

  logic state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RST_VAL;
    end else if (t) begin
      state_q <= ~state_q;
    end
  end

  assign q  = state_q;
  assign qb = ~state_q;

endmodule

// File: rtl/tff_updown_counter.sv
// Modulo-N up/down counter built from a bank of T cells driven by a toggle mask.
// Priority per edge: rst > load > en > hold; wrap is tc delayed by one edge.
module tff_updown_counter
  import tff_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16,
  parameter int RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             tc,
  output logic             wrap
);

  if (WIDTH < 1) begin : g_chk_width
    $error("tff_updown_counter: WIDTH must be >= 1");
  end
  if (MODULUS < 2 || tff_clog2(MODULUS) > WIDTH) begin : g_chk_mod
    $error("tff_updown_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
  end
  if (RST_VAL < 0 || RST_VAL >= MODULUS) begin : g_chk_rst
    $error("tff_updown_counter: RST_VAL must be in 0..MODULUS-1");
  end

  // One extra bit so MODULUS = 2**WIDTH is representable in the compares.
  localparam int               XW       = WIDTH + 1;
  localparam logic [XW-1:0]    MOD_X    = XW'(MODULUS);
  localparam logic [XW-1:0]    MAX_X    = XW'(MODULUS - 1);
  localparam logic [WIDTH-1:0] MAX_W    = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_BITS = WIDTH'(RST_VAL);

  logic [XW-1:0]    q_x;
  logic [XW-1:0]    d_x;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] toggle;
  logic             at_max;
  logic             at_zero;
  logic             wrap_q;
  logic             wrap_d;

  assign q_x     = {1'b0, q};
  assign d_x     = {1'b0, d};
  assign at_max  = (q_x == MAX_X);
  assign at_zero = (q_x == '0);

  always_comb begin
    q_d = q;
    if (load) begin
      q_d = (d_x < MOD_X) ? d : MAX_W;
    end else if (en) begin
      if (up == DIR_UP) begin
        q_d = at_max ? '0 : WIDTH'(q_x + XW'(1));
      end else begin
        q_d = at_zero ? MAX_W : WIDTH'(q_x - XW'(1));
      end
    end
  end

  assign toggle = q_d ^ q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    tff_cell #(
      .RST_VAL(RST_BITS[i])
    ) u_cell (
      .clk(clk),
      .rst(rst),
      .t  (toggle[i]),
      .q  (q[i]),
      .qb (qb[i])
    );
  end

  assign tc = en & ~load & (((up == DIR_UP) & at_max) | ((up == DIR_DOWN) & at_zero));

  assign wrap_d = tc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign wrap = wrap_q;

endmodule

// File: tb/tb_tff_updown_counter.sv
// Randomised and directed checks of the modulo-N T-cell counter against a
// plain arithmetic reference; a second instance covers the power-of-two modulus.
module tb_tff_updown_counter;

  localparam int M1 = 10;
  localparam int M2 = 16;
  localparam int R2 = 15;

  logic       clk;
  logic       rst, en, up, load;
  logic [3:0] d, q, qb;
  logic       tc, wrap;

  logic       rst2, en2, up2, load2;
  logic [3:0] d2, q2, qb2;
  logic       tc2, wrap2;

  int errs;
  int n_chk;
  int qm, wm;
  int qm2, wm2;

  tff_updown_counter #(.WIDTH(4), .MODULUS(M1), .RST_VAL(0)) u_dut (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .d(d),
    .q(q), .qb(qb), .tc(tc), .wrap(wrap)
  );

  tff_updown_counter #(.WIDTH(4), .MODULUS(M2), .RST_VAL(R2)) u_dut16 (
    .clk(clk), .rst(rst2), .en(en2), .up(up2), .load(load2), .d(d2),
    .q(q2), .qb(qb2), .tc(tc2), .wrap(wrap2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int ref_next(input int cur, input int m, input bit e, input bit u,
                                  input bit l, input int dv);
    if (l) return (dv < m) ? dv : m - 1;
    if (!e) return cur;
    if (u) return (cur + 1) % m;
    return (cur + m - 1) % m;
  endfunction

  function automatic bit ref_tc(input int cur, input int m, input bit e, input bit u,
                                input bit l);
    return e && !l && ((u && cur == m - 1) || (!u && cur == 0));
  endfunction

  // Called one time unit after a rising edge; returns one time unit after the next.
  task automatic step(input bit e, input bit u, input bit l, input int dv);
    bit t;
    en = e; up = u; load = l; d = 4'(dv);
    #1;
    t = ref_tc(qm, M1, e, u, l);
    chk("tc", int'(tc), int'(t));
    @(posedge clk);
    #1;
    qm = ref_next(qm, M1, e, u, l, dv);
    wm = int'(t);
    chk("q", int'(q), qm);
    chk("qb", int'(qb), 15 - qm);
    chk("wrap", int'(wrap), wm);
  endtask

  task automatic step2(input bit e, input bit u, input bit l, input int dv);
    bit t;
    en2 = e; up2 = u; load2 = l; d2 = 4'(dv);
    #1;
    t = ref_tc(qm2, M2, e, u, l);
    chk("tc16", int'(tc2), int'(t));
    @(posedge clk);
    #1;
    qm2 = ref_next(qm2, M2, e, u, l, dv);
    wm2 = int'(t);
    chk("q16", int'(q2), qm2);
    chk("qb16", int'(qb2), 15 - qm2);
    chk("wrap16", int'(wrap2), wm2);
  endtask

  // Asserts rst between edges and checks the asynchronous response.
  task automatic mid_reset();
    #3;
    en = 1'b0; load = 1'b0;
    rst = 1'b1;
    #1;
    qm = 0; wm = 0;
    chk("rst_q", int'(q), 0);
    chk("rst_qb", int'(qb), 15);
    chk("rst_wrap", int'(wrap), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rel_q", int'(q), qm);
  endtask

  initial begin
    errs = 0; n_chk = 0;
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; d = '0;
    rst2 = 1'b1; en2 = 1'b0; up2 = 1'b1; load2 = 1'b0; d2 = '0;
    qm = 0; wm = 0; qm2 = R2; wm2 = 0;
    #12;
    chk("init_q", int'(q), 0);
    chk("init_qb", int'(qb), 15);
    chk("init_wrap", int'(wrap), 0);
    chk("init_q16", int'(q2), R2);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) step(1, 1, 0, 0);
    chk("s1_end", int'(q), 2);

    step(0, 0, 1, 0);
    for (int i = 0; i < 12; i++) step(1, 0, 0, 0);

    step(1, 1, 1, 7);
    chk("s3_load", int'(q), 7);
    step(1, 1, 1, 13);
    chk("s3_clamp", int'(q), 9);

    step(0, 1, 1, 4);
    step(1, 1, 0, 0);
    chk("s4_five", int'(q), 5);
    mid_reset();
    step(1, 1, 0, 0);
    chk("s4_after", int'(q), 1);

    step(0, 1, 1, 3);
    for (int i = 0; i < 5; i++) step(0, i[0], 0, 0);
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    chk("s5_dir", int'(q), 2);

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        mid_reset();
      end else begin
        step($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 7) == 0,
             int'($urandom_range(0, 15)));
      end
    end

    @(negedge clk);
    rst2 = 1'b0;
    @(posedge clk);
    #1;
    chk("s6_q16", int'(q2), R2);
    step2(1, 1, 0, 0);
    chk("s6_wrapq", int'(q2), 0);
    chk("s6_wrap", int'(wrap2), 1);
    for (int i = 0; i < 150; i++) begin
      step2($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 9) == 0,
            int'($urandom_range(0, 15)));
    end

    $display("Result: errors=%0d of %0d checks", errs, n_chk);
    $finish;
  end

endmodule

// File: doc/tff_updown_counter.md
Name: tff_updown_counter

Overview:
- Parametrised synchronous modulo-N up/down counter.
- Built as a bank of T flip-flop cells driven by a computed toggle mask.
- Next generation of the single-bit T flip-flop: adds configurable width, configurable modulus, up/down direction, enable, parallel load, terminal-count detection and a wrap event.
- Used as a general-purpose event/divide counter in downstream sequential blocks.

Parameters:
- WIDTH, 4: counter width in bits. Must be >= 1.
- MODULUS, 16: count range is 0..MODULUS-1. Must satisfy 2 <= MODULUS <= 2**WIDTH.
- RST_VAL, 0: value of q after reset. Must be < MODULUS.

Ports:
- clk, input, 1: single clock; all state updates on its rising edge.
- rst, input, 1: reset, asynchronous, active-high.
- en, input, 1: count enable.
- up, input, 1: direction; 1 = increment, 0 = decrement.
- load, input, 1: synchronous parallel load request.
- d, input, WIDTH: load value.
- q, output, WIDTH: counter state (registered).
- qb, output, WIDTH: bitwise complement of q (registered, always ~q).
- tc, output, 1: terminal count (combinational).
- wrap, output, 1: registered one-cycle pulse after a wrap.

Behaviour:
- Reset:
  - rst high asserts immediately, independent of clk: q = RST_VAL, qb = ~RST_VAL, wrap = 0.
  - rst is held internally while high. The first edge after deassertion behaves normally.
  - Reset mid-count discards the count in progress.
- Priority at each rising clk edge: rst > load > en > hold.
- Load:
  - q <= d if d < MODULUS, else q <= MODULUS-1 (clamp).
  - load ignores en and up. wrap <= 0.
- Count (en=1, load=0):
  - up=1: q <= (q == MODULUS-1) ? 0 : q+1.
  - up=0: q <= (q == 0) ? MODULUS-1 : q-1.
- Hold (en=0, load=0): q unchanged, wrap <= 0.
- Implementation rule:
  - Each bit is a T cell. Toggle mask T = q_next XOR q, applied to the cells.
  - A plain D-register next-state assignment is not acceptable.
  - qb is the cell's complementary output, not a separate register.
- Arithmetic: computed at WIDTH+1 bits internally to avoid overflow when MODULUS = 2**WIDTH. The result is truncated to WIDTH bits.
- tc = en & ~load & ((up & q == MODULUS-1) | (~up & q == 0)). It is purely combinational and is valid in the cycle before the wrap edge.
- wrap <= tc on each non-reset edge. It is high for exactly one cycle after every wrap-around, 0 otherwise.
- Latency:
  - q reflects load or count one edge after the request.
  - wrap lags tc by one edge.
- Direction change mid-count takes effect on the next edge with no dead cycle.
- Power-of-two MODULUS: wrap logic reduces to natural rollover and must still produce tc/wrap identically.
- Parameter violations must stop elaboration with an error message.

Decomposition:
- Shared package, tff_pkg:
  - mode constant DIR_UP = 1'b1, DIR_DOWN = 1'b0.
  - clog2-style width helper used by parameter checks.
- Sub-module tff_cell:
  - Single-bit T flip-flop with async active-high rst and parametrised reset value.
  - Ports: clk, rst, t, q, qb.
  - Instantiated WIDTH times via generate.
- The top level holds next-state/mask logic, tc and the wrap register only.

Test Plan:
All scenarios use WIDTH=4, MODULUS=10, RST_VAL=0 unless noted.
1. Reset then en=1, up=1 for 12 edges -> q = 1..9, 0, 1, 2. qb = ~q every cycle. tc high only while q=9. wrap high only the cycle q=0 first appears.
2. Preload q=0, then en=1, up=0 -> q = 9, 8, ... wrap pulses on the 0->9 transition. tc high while q=0.
3. load=1, d=4'd7 with en=1 on the same edge -> q=7 (load wins). Then load d=4'd13 -> q=9 (clamped). tc=0 during both load cycles.
4. Count to q=5, then assert rst between clock edges -> q=0, qb=4'hF, wrap=0 immediately. After release, the next enabled edge gives q=1.
5. en=0 for 5 edges at q=3 with up toggling -> q stays 3, wrap=0, tc=0. Then flip up from 1 to 0 at q=3 with en=1 -> next q=2.
6. Rebuild with WIDTH=4, MODULUS=16, RST_VAL=15 -> after reset q=15, tc=1 when en=1 and up=1. Next edge q=0 with wrap=1. MODULUS=17 fails elaboration.
